// File: rtl/keypad_scanner_if.sv
// Keypad matrix bus: column strobes out, row returns in, debounced key events to the lock FSM.
// master = scanner side, slave = keypad/lock side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates one-hot column strobes, debounces a single pressed key,
// and reports it as a one-cycle key_valid pulse plus a key_held level until debounced release.
module keypad_scanner #(
  parameter int unsigned clk_freq    = 125_000_000,
  parameter int unsigned stable_time = 1000,
  parameter int unsigned col_dwell   = 16
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned STABLE_CYCLES = (clk_freq / 1_000_000) * stable_time;
  localparam int unsigned DW = (col_dwell > 1) ? $clog2(col_dwell) : 1;
  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [DW-1:0] DWELL_LAST  = DW'(col_dwell - 1);
  localparam logic [DW-1:0] DWELL_ONE   = DW'(1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_ONE  = SW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_meta_q;
  logic [3:0]    row_s_q;
  logic [3:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] deb_q, deb_d;
  logic [3:0]    cap_row_q, cap_row_d;
  logic [1:0]    cap_col_q, cap_col_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic [3:0]    col_rot;
  logic          row_onehot;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // row is asynchronous to clk; every decision below looks only at row_s_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '0;
      row_s_q    <= '0;
    end else begin
      row_meta_q <= kp.row;
      row_s_q    <= row_meta_q;
    end
  end

  assign col_rot    = {col_q[2:0], col_q[3]};
  // Exactly one row bit: zero rows means no key, several mean ghosting.
  assign row_onehot = (row_s_q != '0) && ((row_s_q & (row_s_q - 4'd1)) == '0);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_onehot) begin
            cap_row_d = row_s_q;
            cap_col_d = onehot_idx(col_q);
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_rot;
          end
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end

      DEBOUNCE: begin
        if (row_s_q == cap_row_q) begin
          if (deb_q == STABLE_LAST) begin
            key_valid_d = 1'b1;
            key_code_d  = {onehot_idx(cap_row_q), cap_col_q};
            key_held_d  = 1'b1;
            deb_d       = '0;
            state_d     = HELD;
          end else begin
            deb_d = deb_q + STABLE_ONE;
          end
        end else begin
          col_d   = col_rot;
          dwell_d = '0;
          state_d = SCAN;
        end
      end

      HELD: begin
        // Counts only consecutive all-clear cycles; any row activity restarts the release window.
        if (row_s_q == '0) begin
          if (deb_q == STABLE_LAST) begin
            key_held_d = 1'b0;
            col_d      = col_rot;
            dwell_d    = '0;
            deb_d      = '0;
            state_d    = SCAN;
          end else begin
            deb_d = deb_q + STABLE_ONE;
          end
        end else begin
          deb_d = '0;
        end
      end

      default: begin
        state_d = SCAN;
        col_d   = 4'b0001;
        dwell_d = '0;
        deb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= 4'b0001;
      dwell_q     <= '0;
      deb_q       <= '0;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix keypad model drives the rows from the strobed columns;
// observed key events are compared with timing and codes derived from the scanner's behavioural rules.
module tb_keypad_scanner;

  localparam int unsigned CLK_FREQ    = 125_000_000;
  localparam int unsigned STABLE_TIME = 1;
  localparam int unsigned COL_DWELL   = 4;
  localparam int unsigned STABLE      = (CLK_FREQ / 1_000_000) * STABLE_TIME;
  localparam int unsigned SYNC        = 2;
  localparam int unsigned LAT_MIN     = SYNC + STABLE;
  localparam int unsigned LAT_MAX     = SYNC + STABLE + 4 * COL_DWELL + 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic        force_en;
  logic [3:0]  force_row;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned fails = 0;

  int unsigned pulse_t[$];
  logic [3:0]  pulse_c[$];
  logic        pulse_h[$];
  int unsigned fall_t[$];
  logic [3:0]  fall_col[$];
  logic        prev_held = 1'b0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .clk_freq   (CLK_FREQ),
    .stable_time(STABLE_TIME),
    .col_dwell  (COL_DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key index r*4+c closes the switch between column c and row r.
  function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = '0;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && c[ci]) r[ri] = 1'b1;
    return r;
  endfunction

  assign kp.row = force_en ? force_row : matrix(keys, kp.col);

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      pulse_t.push_back(cyc);
      pulse_c.push_back(kp.key_code);
      pulse_h.push_back(kp.key_held);
    end
    if (prev_held && kp.key_held === 1'b0) begin
      fall_t.push_back(cyc);
      fall_col.push_back(kp.col);
    end
    prev_held <= (rst === 1'b1) ? 1'b0 : (kp.key_held === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_events();
    pulse_t.delete();
    pulse_c.delete();
    pulse_h.delete();
    fall_t.delete();
    fall_col.delete();
  endtask

  function automatic logic [3:0] next_col(input int unsigned c);
    logic [3:0] v;
    v = 4'b0001 << ((c + 1) % 4);
    return v;
  endfunction

  task automatic clean_press(input int unsigned r, input int unsigned c, input int unsigned hold);
    int unsigned t0, trel, lat;
    logic [3:0] code;
    code = 4'(r * 4 + c);
    clear_events();
    t0 = cyc;
    keys[r*4+c] = 1'b1;
    step(hold);
    check("press_held_level", kp.key_held, 1'b1);
    trel = cyc;
    keys = '0;
    step(200);
    check("press_pulse_count", pulse_t.size(), 1);
    if (pulse_t.size() > 0) begin
      lat = pulse_t[0] - t0;
      check("press_code", pulse_c[0], code);
      check("press_held_with_pulse", pulse_h[0], 1'b1);
      check("press_latency_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1'b1);
    end
    check("release_fall_count", fall_t.size(), 1);
    if (fall_t.size() > 0) begin
      check("release_fall_delay", fall_t[0] - trel, SYNC + STABLE);
      check("release_col_resume", fall_col[0], next_col(c));
    end
    check("code_kept_after_release", kp.key_code, code);
    check("held_low_after_release", kp.key_held, 1'b0);
  endtask

  task automatic bounce(input int unsigned r, input int unsigned c);
    int unsigned k, tlast, lat;
    k = r * 4 + c;
    clear_events();
    tlast = cyc;
    for (int i = 0; i < 15; i++) begin
      keys[k] = ~keys[k];
      tlast = cyc;
      step(20);
    end
    check("bounce_no_pulse", pulse_t.size(), 0);
    step(380);
    check("bounce_pulse_count", pulse_t.size(), 1);
    if (pulse_t.size() > 0) begin
      lat = pulse_t[0] - tlast;
      check("bounce_code", pulse_c[0], 4'(k));
      check("bounce_latency_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1'b1);
    end
    keys = '0;
    step(200);
    check("bounce_released", kp.key_held, 1'b0);
  endtask

  task automatic ghost();
    logic [3:0] seen, prev;
    int unsigned chg;
    clear_events();
    keys = 16'h0011;
    seen = kp.col;
    prev = kp.col;
    chg  = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      seen = seen | kp.col;
      if (kp.col !== prev) chg++;
      prev = kp.col;
    end
    check("ghost_no_pulse", pulse_t.size(), 0);
    check("ghost_all_cols_seen", seen, 4'hF);
    check("ghost_rotations", chg, 200 / COL_DWELL);
    check("ghost_not_held", kp.key_held, 1'b0);
    keys = '0;
    step(20);
  endtask

  task automatic hold_two(input int unsigned a, input int unsigned b);
    clear_events();
    keys[a] = 1'b1;
    step(400);
    check("hold2_first_count", pulse_t.size(), 1);
    if (pulse_t.size() > 0) check("hold2_first_code", pulse_c[0], 4'(a));
    keys[b] = 1'b1;
    step(400);
    check("hold2_second_ignored", pulse_t.size(), 1);
    check("hold2_still_held", kp.key_held, 1'b1);
    keys = '0;
    step(200);
    check("hold2_release_fall", fall_t.size(), 1);
    check("hold2_code_kept", kp.key_code, 4'(a));
    clear_events();
    keys[b] = 1'b1;
    step(300);
    check("hold2_repress_count", pulse_t.size(), 1);
    if (pulse_t.size() > 0) check("hold2_repress_code", pulse_c[0], 4'(b));
    keys = '0;
    step(200);
  endtask

  task automatic reset_in_debounce(input int unsigned r, input int unsigned c);
    logic [3:0] target, seen;
    int unsigned n;
    logic frozen;
    target = 4'b0001 << c;
    clear_events();
    keys[r*4+c] = 1'b1;
    step(20);
    n = 0;
    while (kp.col !== target && n < 40) begin
      step(1);
      n++;
    end
    check("rstdb_col_reached", kp.col, target);
    frozen = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (kp.col !== target) frozen = 1'b0;
    end
    check("rstdb_col_frozen", frozen, 1'b1);
    rst  = 1'b1;
    keys = '0;
    step(2);
    check("rstdb_col", kp.col, 4'b0001);
    check("rstdb_valid", kp.key_valid, 1'b0);
    check("rstdb_held", kp.key_held, 1'b0);
    check("rstdb_code", kp.key_code, 4'd0);
    rst  = 1'b0;
    seen = '0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      seen = seen | kp.col;
    end
    check("rstdb_no_pulse", pulse_t.size(), 0);
    check("rstdb_scan_restart", seen, 4'hF);
  endtask

  initial begin
    int unsigned a, b;
    rst       = 1'b1;
    keys      = '0;
    force_en  = 1'b1;
    force_row = 4'b0100;
    step(2);
    check("rst_col", kp.col, 4'b0001);
    check("rst_valid", kp.key_valid, 1'b0);
    check("rst_held", kp.key_held, 1'b0);
    check("rst_code", kp.key_code, 4'd0);
    check("rst_no_pulse", pulse_t.size(), 0);
    rst      = 1'b0;
    force_en = 1'b0;
    step(20);

    clean_press(2, 1, 1000);
    for (int i = 0; i < 5; i++)
      clean_press($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(300, 800));

    bounce(2, 1);
    bounce($urandom_range(0, 3), $urandom_range(0, 3));

    ghost();

    hold_two(0, 15);
    a = $urandom_range(0, 15);
    b = (a + $urandom_range(1, 15)) % 16;
    hold_two(a, b);

    reset_in_debounce($urandom_range(0, 3), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active end of the 4x4 keypad matrix interface used by the digital lock.
- Drives one-hot column strobes on col and samples the returned row lines.
- Debounces a single pressed key and emits a one-cycle key_valid pulse with a 4-bit key code, plus a level key_held, to the lock FSM.
- Sits between the keypad pins and digital_lock_top's lock logic.

Parameters:
clk_freq, 125_000_000, system clock frequency in Hz
stable_time, 1000, debounce/release time in microseconds; STABLE_CYCLES = (clk_freq/1_000_000)*stable_time
col_dwell, 16, clock cycles each column is driven before its rows are sampled (settle time)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
row  input  4  keypad row returns, active-high (pulled low externally), asynchronous to clk
col  output 4  one-hot active-high column strobe
key_code  output 4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
key_valid  output 1  one-cycle pulse when a debounced press is accepted
key_held  output 1  high from acceptance until debounced release completes

Behaviour:
- Reset (rst=1 at a clk edge): col=4'b0001, key_code=0, key_valid=0, key_held=0, state=SCAN, dwell and debounce counters=0, synchronizer flops=0. Reset mid-debounce or mid-hold aborts; no key_valid is produced.
- row passes through a 2-flop synchronizer (row_s). All decisions use row_s.
- Counter widths are $clog2 of their terminal count, minimum 1 bit.
- SCAN:
  - The dwell counter runs 0..col_dwell-1. On the terminal cycle, the block samples row_s.
  - If row_s is exactly one-hot: capture row_s and the current col index, clear the debounce counter, and go to DEBOUNCE. col stays frozen.
  - Otherwise (zero bits set, or two or more bits set, i.e. ghosting): rotate col left (4'b1000 wraps to 4'b0001), clear the dwell counter, and stay in SCAN.
- DEBOUNCE:
  - col is frozen.
  - Each cycle row_s equals the captured row, the debounce counter increments.
  - Any mismatch returns to SCAN. col rotates to the next column, no output change.
  - When the counter reaches STABLE_CYCLES-1 with row_s still matching: on the next edge key_valid=1 for exactly one cycle, key_code={row_idx,col_idx}, key_held=1, and the state goes to HELD.
  - row_idx/col_idx are the one-hot bit positions (bit0 -> 0).
- HELD:
  - col is frozen. key_code holds its value.
  - The debounce counter counts consecutive cycles with row_s==0 and clears on any nonzero row_s.
  - At STABLE_CYCLES-1: key_held=0, rotate col to the next column, go to SCAN.
  - A second key pressed while held is ignored. There is no repeat or auto-repeat.
- key_code keeps its last accepted value until the next acceptance. It is not cleared on release.
- Latency: a clean press on the currently strobed column produces key_valid no earlier than 2 (sync) + remaining dwell + STABLE_CYCLES cycles after row changes. Worst case adds 3*col_dwell.
- STABLE_CYCLES=1 is legal: key_valid follows one matching cycle in DEBOUNCE.

Test Plan:
- Use clk_freq=125_000_000, stable_time=1 (125 cycles), col_dwell=4 for all scenarios.
- Reset: assert rst for 2 cycles with row=4'b0100 -> col=4'b0001, key_valid=0, key_held=0, key_code=0. No pulse while rst is high.
- Clean press: a model returns row=4'b0100 only while col=4'b0010 (key r2,c1), held 1000 cycles, then released -> exactly one key_valid with key_code=4'b1001. key_held rises with it and falls 125+2 cycles after release. col then resumes at 4'b0100.
- Bounce: row toggles 0/1 every 20 cycles for 300 cycles, then is stable -> no key_valid during bouncing. A single pulse arrives ≥125 cycles after the last toggle.
- Ghosting: row=4'b0011 on col 4'b0001 -> no DEBOUNCE entry, col keeps rotating, key_valid never asserts.
- Hold plus second key: hold key r0,c0 (code 0), then also press r3,c3 -> exactly one pulse (code 0). No pulse for code 15 until both are released and r3,c3 is pressed again.
- Reset in DEBOUNCE: assert rst 50 cycles into debounce -> no key_valid, col=4'b0001, and scanning restarts.
